uart_imem_loader: RTL and testbench

Boot-time program loader upstream of the single-cycle CPU's instruction memory. Receives a framed program image over a UART RX line and writes it word by word into the instruction memory. Holds the CPU in reset (cpu_resetn low) until the image is fully loaded, then releases it. Sits at board top level beside the CPU/memory top.

---
 rtl/uart_imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a framed program image over UART (8N1) and writes it into instruction memory,
// holding the CPU in reset until the image is complete. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t END_STATE = L_CSUM;
`else
  localparam ld_state_t END_STATE = L_DONE;
`endif

  logic             rx_p0, rx_p1, rx_p2;
  rx_state_t        rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  ld_state_t        ld_state, ld_state_d;
  logic             loading;
  logic [15:0]      len, len_full;
  logic [ADDR_W:0]  idx, idx_inc;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_sh;

  // Stage p0/p1: metastability synchronizer; p2 holds the previous sample for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state)
      R_IDLE:  if (rx_p2 && !rx_p1) rx_state_d = R_START;
      R_START: if (rx_cnt == HALF_LAST) rx_state_d = rx_p1 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_d = R_STOP;
      R_STOP:
        if (rx_cnt == BIT_LAST) begin
          if (rx_p1) begin
            byte_valid = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            frame_err  = 1'b1;
            rx_state_d = R_BREAK;
          end
        end
      R_BREAK: if (rx_p1) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  // The bit counter restarts on every state change, so each phase times itself from its own entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_d;
      if (rx_state_d != rx_state || rx_cnt == BIT_LAST) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_state != R_DATA) rx_bit <= '0;
      else if (rx_cnt == BIT_LAST) rx_bit <= rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_state == R_DATA && rx_cnt == BIT_LAST) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clock) begin
    if (ld_state_d == L_LEN_HI && ld_state != L_LEN_HI) csum <= 8'h00;
    else if (byte_valid && ld_state inside {L_LEN_HI, L_LEN_LO, L_DATA}) csum <= csum ^ rx_shift;
  end
`endif

  assign loading = ld_state inside {L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM};

  always_comb begin
    ld_state_d = ld_state;
    idx_inc    = idx + {{ADDR_W{1'b0}}, 1'b1};
    len_full   = {len[15:8], rx_shift};
    unique case (ld_state)
      L_IDLE, L_DONE, L_ERR:
        if (byte_valid && rx_shift == SYNC_BYTE) ld_state_d = L_LEN_HI;
      L_LEN_HI: if (byte_valid) ld_state_d = L_LEN_LO;
      L_LEN_LO:
        if (byte_valid) begin
          if (32'(len_full) > MAX_WORDS) ld_state_d = L_ERR;
          else if (len_full == 16'd0) ld_state_d = END_STATE;
          else ld_state_d = L_DATA;
        end
      L_DATA:
        if (byte_valid && byte_cnt == 2'd3 && 16'(idx_inc) == len) ld_state_d = END_STATE;
`ifdef LOADER_CHECKSUM_EN
      L_CSUM: if (byte_valid) ld_state_d = (rx_shift == csum) ? L_DONE : L_ERR;
`else
      L_CSUM: ld_state_d = L_ERR;
`endif
      default: ld_state_d = L_IDLE;
    endcase
    if (frame_err && loading) ld_state_d = L_ERR;
  end

  // Status flags follow the next state; cpu_resetn waits one full cycle inside DONE so it
  // trails the final write strobe and drops immediately on a restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state   <= L_IDLE;
      byte_cnt   <= '0;
      idx        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_resetn <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ld_state   <= ld_state_d;
      imem_we    <= 1'b0;
      busy       <= ld_state_d inside {L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM};
      done       <= (ld_state_d == L_DONE);
      err        <= (ld_state_d == L_ERR);
      cpu_resetn <= (ld_state == L_DONE) && (ld_state_d == L_DONE);
      if (ld_state_d == L_LEN_HI && ld_state != L_LEN_HI) begin
        byte_cnt <= '0;
        idx      <= '0;
      end
      if (byte_valid && ld_state == L_DATA) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_addr  <= idx[ADDR_W-1:0];
          imem_wdata <= {word_sh, rx_shift};
          idx        <= idx_inc;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (byte_valid) begin
      if (ld_state == L_LEN_HI) len[15:8] <= rx_shift;
      if (ld_state == L_LEN_LO) len[7:0]  <= rx_shift;
      if (ld_state == L_DATA)   word_sh   <= {word_sh[15:0], rx_shift};
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: a byte-stream reference model predicts writes and final status.
module tb_uart_imem_loader;
  localparam int CPB   = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int ST_IDLE = 0, ST_BUSY = 1, ST_DONE = 2, ST_ERR = 3;

  logic          clock = 1'b0;
  logic          reset, rx;
  logic          imem_we, cpu_resetn, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;
  int         model_st = ST_IDLE;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic check_status(input string name, input int st);
    logic [3:0] e;
    case (st)
      ST_BUSY: e = 4'b1000;
      ST_DONE: e = 4'b0101;
      ST_ERR:  e = 4'b0010;
      default: e = 4'b0000;
    endcase
    check(name, {60'd0, busy, done, err, cpu_resetn}, {60'd0, e});
  endtask

  // Reference model: walks the byte stream frame by frame, queues the expected writes and
  // returns the loader status at the end of the stream.
  function automatic int model_stream(input logic [7:0] bs[$], input int st_in);
    int st = st_in;
    int i = 0;
    int n;
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         wr;
    while (i < bs.size()) begin
      if (bs[i] != 8'hA5) begin
        i++;
        continue;
      end
      st = ST_BUSY;
      if (i + 2 >= bs.size()) return st;
      n  = {bs[i+1], bs[i+2]};
      cs = bs[i+1] ^ bs[i+2];
      i += 3;
      if (n > DEPTH) begin
        st = ST_ERR;
        continue;
      end
      for (int k = 0; k < n; k++) begin
        if (i + 3 >= bs.size()) return st;
        w  = {bs[i], bs[i+1], bs[i+2], bs[i+3]};
        cs = cs ^ bs[i] ^ bs[i+1] ^ bs[i+2] ^ bs[i+3];
        wr.addr = AW'(k);
        wr.data = w;
        exp_q.push_back(wr);
        i += 4;
      end
`ifdef LOADER_CHECKSUM_EN
      if (i >= bs.size()) return st;
      st = (bs[i] == cs) ? ST_DONE : ST_ERR;
      i++;
`else
      st = ST_DONE;
`endif
    end
    return st;
  endfunction

  task automatic append_frame(input logic [31:0] words[$], input bit bad_cs);
    logic [15:0] n;
    logic [7:0]  cs;
    n  = 16'(words.size());
    cs = n[15:8] ^ n[7:0];
    tx_q.push_back(8'hA5);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    foreach (words[k]) begin
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(words[k][8*b +: 8]);
        cs = cs ^ words[k][8*b +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(bad_cs ? (cs ^ 8'h01) : cs);
`else
    if (bad_cs) cs = 8'h00;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic run_stream(input string name, input int glitch_at);
    int gap;
    model_st = model_stream(tx_q, model_st);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == glitch_at) begin
        rx = 1'b0;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
      end
      send_byte(tx_q[i], 1'b1);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      repeat (gap) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    check_status(name, model_st);
    tx_q.delete();
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (reset === 1'b0 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h expected=none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write got=%0h:%08h expected=%0h:%08h", imem_addr, imem_wdata, e.addr, e.data);
        end
      end
      check("cpu_held_during_write", {63'd0, cpu_resetn}, 64'd0);
    end
  end

  initial begin
    logic [31:0] wq[$];
    logic [7:0]  jb;
    int          n;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      repeat (50) @(negedge clock);
      check("idle_outputs", {23'd0, imem_we, imem_addr, imem_wdata, cpu_resetn, busy, done, err}, 64'd0);
    end

    wq = {32'h12345678, 32'hDEADBEEF};
    append_frame(wq, 1'b0);
    run_stream("two_words", -1);
    check("hold_addr", {60'd0, imem_addr}, 64'd1);
    check("hold_data", {32'd0, imem_wdata}, 64'hDEADBEEF);

    tx_q = {8'h00, 8'hFF};
    wq.delete();
    append_frame(wq, 1'b0);
    run_stream("zero_len", -1);

    tx_q = {8'hA5, 8'h00, 8'h11};
    run_stream("oversize", -1);
    wq = {32'h00000001};
    append_frame(wq, 1'b0);
    run_stream("after_err", -1);

    tx_q = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22};
    run_stream("mid_data_busy", -1);
    send_byte(8'h33, 1'b0);
    repeat (2 * CPB) @(negedge clock);
    model_st = ST_ERR;
    check_status("frame_err", model_st);

    wq = {32'h00000001};
    append_frame(wq, 1'b0);
    run_stream("glitch", 6);

`ifdef LOADER_CHECKSUM_EN
    tx_q = {8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_stream("csum_ok", -1);
    tx_q = {8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    run_stream("csum_bad", -1);
`endif

    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        tx_q.push_back(jb);
      end
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(DEPTH + 1, 600);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
      end else begin
        wq.delete();
        n = $urandom_range(0, DEPTH);
        for (int k = 0; k < n; k++) wq.push_back($urandom);
        append_frame(wq, $urandom_range(0, 3) == 0);
      end
      run_stream("random_frame", -1);
    end

    repeat (20) @(negedge clock);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
